// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the multi-line I2S / left-justified receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_multi_if.sv
// i2s_rx_multi_if: frame output bus with valid/ready handshake and sticky overflow flag.
// The receiver drives through the master modport, the audio pipeline sits on the slave side.
interface i2s_rx_multi_if #(
  parameter int NUM_LINES = 1,
  parameter int OUT_W     = 32
);

  logic [2*NUM_LINES*OUT_W-1:0] data_out;
  logic                         data_valid_out;
  logic                         data_ready_in;
  logic                         ovf_out;
  logic                         ovf_clr_in;

  modport master (
    output data_out,
    output data_valid_out,
    output ovf_out,
    input  data_ready_in,
    input  ovf_clr_in
  );

  modport slave (
    input  data_out,
    input  data_valid_out,
    input  ovf_out,
    output data_ready_in,
    output ovf_clr_in
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: brings an asynchronous pad signal into the system clock domain and
// reports its synchronised level together with single-cycle rise and fall pulses.
module i2s_sync_edge
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus a copy of the last synchronised level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2s_rx_multi.sv
// i2s_rx_multi: oversampling I2S / left-justified receiver for NUM_LINES data lines that
// share one bit clock and word select. Emits one stereo frame per line per ws period.
// Optional build macro I2S_RX_SIGN_EXT_EN: right-justify and sign-extend each channel
// instead of MSB-aligning it in the OUT_W field.
module i2s_rx_multi
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32,
  parameter int NUM_LINES = 1,
  parameter int OUT_W     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 sck_in,
  input  logic                 ws_in,
  input  logic [NUM_LINES-1:0] sd_in,
  input  logic                 mode_in,
  i2s_rx_multi_if.master       out_if
);

  localparam int CNT_W   = $clog2(SLOT_W + 1);
  localparam int FRAME_W = 2 * NUM_LINES * OUT_W;
  localparam logic [SAMPLE_W-1:0] MSB_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic                 sck_rise;
  logic                 sck_level_unused, sck_fall_unused;
  logic                 ws_sync, ws_rise_unused, ws_fall_unused;
  logic [NUM_LINES-1:0] sd_sync, sd_rise_unused, sd_fall_unused;

  state_e                             state_q, state_d;
  mode_e                              mode_q, mode_d;
  logic                               ws_prev_q, ws_prev_d;
  logic                               ws_change;
  logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
  logic [NUM_LINES-1:0][SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic                               emit;
  logic [FRAME_W-1:0]                 frame_d;

  i2s_sync_edge u_sck_sync (
    .clk(clk_in), .rst_n(rst_n_in), .din(sck_in),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  i2s_sync_edge u_ws_sync (
    .clk(clk_in), .rst_n(rst_n_in), .din(ws_in),
    .level(ws_sync), .rise(ws_rise_unused), .fall(ws_fall_unused)
  );

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_sd_sync
    i2s_sync_edge u_sd_sync (
      .clk(clk_in), .rst_n(rst_n_in), .din(sd_in[g]),
      .level(sd_sync[g]), .rise(sd_rise_unused[g]), .fall(sd_fall_unused[g])
    );
  end

  assign ws_change = ws_sync ^ ws_prev_q;

  // Writes one bit at MSB-first index k; for k >= SAMPLE_W the mask shifts out to zero,
  // so surplus slot bits are discarded without a separate compare.
  function automatic logic [SAMPLE_W-1:0] put_bit(input logic [SAMPLE_W-1:0] word,
                                                  input logic [CNT_W-1:0]    k,
                                                  input logic                b);
    logic [SAMPLE_W-1:0] mask;
    logic [SAMPLE_W-1:0] res;
    mask = MSB_BIT >> k;
    res  = b ? (word | mask) : (word & ~mask);
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] k);
    return (k == CNT_W'(SLOT_W)) ? k : k + 1'b1;
  endfunction

  // Places a captured sample into its OUT_W output field
  function automatic logic [OUT_W-1:0] fmt(input logic [SAMPLE_W-1:0] s);
    logic [OUT_W-1:0] r;
`ifdef I2S_RX_SIGN_EXT_EN
    r = {OUT_W{s[SAMPLE_W-1]}};
    r[SAMPLE_W-1:0] = s;
`else
    r = '0;
    r[OUT_W-1 -: SAMPLE_W] = s;
`endif
    return r;
  endfunction

  // Next-state logic: on each sck rise track ws, steer the data bit into the current
  // channel (or the previous one on an I2S ws-change edge) and flag frame completion
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ws_prev_d = ws_prev_q;
    bit_cnt_d = bit_cnt_q;
    left_d    = left_q;
    right_d   = right_q;
    emit      = 1'b0;
    if (sck_rise) begin
      ws_prev_d = ws_sync;
      case (state_q)
        SYNC: begin
          if (ws_change && !ws_sync) begin
            state_d = LEFT;
            mode_d  = mode_e'(mode_in);
            left_d  = '0;
            if (mode_e'(mode_in) == MODE_LJ) begin
              for (int l = 0; l < NUM_LINES; l++) left_d[l] = put_bit('0, '0, sd_sync[l]);
              bit_cnt_d = CNT_W'(1);
            end else begin
              bit_cnt_d = '0;
            end
          end
        end
        LEFT: begin
          if (ws_change) begin
            state_d = RIGHT;
            right_d = '0;
            if (mode_q == MODE_I2S) begin
              for (int l = 0; l < NUM_LINES; l++) left_d[l] = put_bit(left_q[l], bit_cnt_q, sd_sync[l]);
              bit_cnt_d = '0;
            end else begin
              for (int l = 0; l < NUM_LINES; l++) right_d[l] = put_bit('0, '0, sd_sync[l]);
              bit_cnt_d = CNT_W'(1);
            end
          end else begin
            for (int l = 0; l < NUM_LINES; l++) left_d[l] = put_bit(left_q[l], bit_cnt_q, sd_sync[l]);
            bit_cnt_d = sat_inc(bit_cnt_q);
          end
        end
        RIGHT: begin
          if (ws_change) begin
            state_d = LEFT;
            emit    = 1'b1;
            left_d  = '0;
            if (mode_q == MODE_I2S) begin
              for (int l = 0; l < NUM_LINES; l++) right_d[l] = put_bit(right_q[l], bit_cnt_q, sd_sync[l]);
              bit_cnt_d = '0;
            end else begin
              for (int l = 0; l < NUM_LINES; l++) left_d[l] = put_bit('0, '0, sd_sync[l]);
              bit_cnt_d = CNT_W'(1);
            end
          end else begin
            for (int l = 0; l < NUM_LINES; l++) right_d[l] = put_bit(right_q[l], bit_cnt_q, sd_sync[l]);
            bit_cnt_d = sat_inc(bit_cnt_q);
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Frame assembly uses the finished left half and the right half including its final I2S bit
  always_comb begin
    frame_d = '0;
    for (int l = 0; l < NUM_LINES; l++) begin
      frame_d[(2*l)*OUT_W   +: OUT_W] = fmt(left_q[l]);
      frame_d[(2*l+1)*OUT_W +: OUT_W] = fmt(right_d[l]);
    end
  end

  // Receiver state, bit counter and per-line sample registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= SYNC;
      mode_q    <= MODE_I2S;
      ws_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ws_prev_q <= ws_prev_d;
      bit_cnt_q <= bit_cnt_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  // Registered output stage: load on emit when the slot is free or being drained,
  // otherwise drop the new frame and raise the sticky overflow flag
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      out_if.data_out       <= '0;
      out_if.data_valid_out <= 1'b0;
      out_if.ovf_out        <= 1'b0;
    end else begin
      if (emit && (!out_if.data_valid_out || out_if.data_ready_in)) begin
        out_if.data_out       <= frame_d;
        out_if.data_valid_out <= 1'b1;
      end else if (!emit && out_if.data_valid_out && out_if.data_ready_in) begin
        out_if.data_valid_out <= 1'b0;
      end
      if (emit && out_if.data_valid_out && !out_if.data_ready_in) begin
        out_if.ovf_out <= 1'b1;
      end else if (out_if.ovf_clr_in) begin
        out_if.ovf_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_multi.sv
// tb_i2s_rx_multi: directed bench for i2s_rx_multi with two data lines, sck = clk/8.
// Expected values honour I2S_RX_SIGN_EXT_EN when the bench is built with that macro.
module tb_i2s_rx_multi;

  logic       clk_in;
  logic       rst_n_in;
  logic       sck_in;
  logic       ws_in;
  logic [1:0] sd_in;
  logic       mode_in;

  i2s_rx_multi_if #(.NUM_LINES(2), .OUT_W(32)) bus ();

  i2s_rx_multi #(
    .SAMPLE_W(24), .SLOT_W(32), .NUM_LINES(2), .OUT_W(32)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sck_in(sck_in), .ws_in(ws_in),
    .sd_in(sd_in), .mode_in(mode_in), .out_if(bus)
  );

  typedef struct {
    logic        mode;
    logic [23:0] l0, r0, l1, r1;
    int          slot;
    logic        junk;
    logic [31:0] msb [4];
    logic [31:0] sx  [4];
  } vec_t;

  vec_t         vecs [6];
  int           checks = 0;
  int           errors = 0;
  int           beats  = 0;
  logic [127:0] last_frame = '0;
  logic [1:0]   delay_sd;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Records every completed handshake, sampled shortly after the clock edge
  always @(posedge clk_in) begin
    #2;
    if (rst_n_in && bus.data_valid_out && bus.data_ready_in) begin
      beats++;
      last_frame = bus.data_out;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] pick(input logic [31:0] msb, input logic [31:0] sx);
`ifdef I2S_RX_SIGN_EXT_EN
    return sx;
`else
    return msb;
`endif
  endfunction

  function automatic logic bit_of(input logic [23:0] s, input int j, input logic junk);
    logic [23:0] sh;
    if (j >= 24) return junk;
    sh = s >> (23 - j);
    return sh[0];
  endfunction

  task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic bit_edge(input logic ws, input logic [1:0] sd);
    sck_in = 1'b0;
    ws_in  = ws;
    sd_in  = sd;
    repeat (4) @(negedge clk_in);
    sck_in = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic send_half(input logic ws, input logic [23:0] s0, input logic [23:0] s1,
                           input logic junk, input int count);
    for (int j = 0; j < count; j++) begin
      logic [1:0] cur;
      cur = {bit_of(s1, j, junk), bit_of(s0, j, junk)};
      if (mode_in) begin
        bit_edge(ws, cur);
      end else begin
        bit_edge(ws, delay_sd);
        delay_sd = cur;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    sck_in   = 1'b0;
    ws_in    = 1'b0;
    sd_in    = 2'b00;
    delay_sd = 2'b00;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int start;
    do_reset();
    mode_in = v.mode;
    bus.data_ready_in = 1'b1;
    start = beats;
    send_half(1'b1, 24'h0, 24'h0, 1'b0, 2);
    send_half(1'b0, v.l0, v.l1, v.junk, v.slot);
    send_half(1'b1, v.r0, v.r1, v.junk, v.slot);
    send_half(1'b0, 24'h0, 24'h0, 1'b0, 1);
    repeat (2) @(negedge clk_in);
    check_output($sformatf("v%0d_beats", idx), 128'(beats - start), 128'(1));
    check_output($sformatf("v%0d_ovf", idx), 128'(bus.ovf_out), 128'(0));
    for (int c = 0; c < 4; c++)
      check_output($sformatf("v%0d_ch%0d", idx, c), 128'(last_frame[c*32 +: 32]),
                   128'(pick(v.msb[c], v.sx[c])));
  endtask

  initial begin
    int start;
    rst_n_in = 1'b0;
    sck_in = 1'b0; ws_in = 1'b0; sd_in = 2'b00; mode_in = 1'b0; delay_sd = 2'b00;
    bus.data_ready_in = 1'b0;
    bus.ovf_clr_in    = 1'b0;

    vecs[0] = '{1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'h0, 24'h0, 32, 1'b1,
                '{32'hA5A5A500, 32'h5A5A5A00, 32'h0, 32'h0},
                '{32'hFFA5A5A5, 32'h005A5A5A, 32'h0, 32'h0}};
    vecs[1] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 24'h0, 24'h0, 32, 1'b0,
                '{32'hA5A5A500, 32'h5A5A5A00, 32'h0, 32'h0},
                '{32'hFFA5A5A5, 32'h005A5A5A, 32'h0, 32'h0}};
    vecs[2] = '{1'b0, 24'hFFFF00, 24'h123400, 24'h0, 24'h0, 16, 1'b0,
                '{32'hFFFF0000, 32'h12340000, 32'h0, 32'h0},
                '{32'hFFFFFF00, 32'h00123400, 32'h0, 32'h0}};
    vecs[3] = '{1'b1, 24'hFFFF00, 24'h123400, 24'h0, 24'h0, 16, 1'b0,
                '{32'hFFFF0000, 32'h12340000, 32'h0, 32'h0},
                '{32'hFFFFFF00, 32'h00123400, 32'h0, 32'h0}};
    vecs[4] = '{1'b0, 24'h000001, 24'h0, 24'h0, 24'h800000, 32, 1'b0,
                '{32'h00000100, 32'h0, 32'h0, 32'h80000000},
                '{32'h00000001, 32'h0, 32'h0, 32'hFF800000}};
    vecs[5] = '{1'b1, 24'h123456, 24'hABCDEF, 24'h7FFFFF, 24'hC00003, 32, 1'b1,
                '{32'h12345600, 32'hABCDEF00, 32'h7FFFFF00, 32'hC0000300},
                '{32'h00123456, 32'hFFABCDEF, 32'h007FFFFF, 32'hFFC00003}};

    // Reset state
    do_reset();
    check_output("rst_valid", 128'(bus.data_valid_out), 128'(0));
    check_output("rst_ovf", 128'(bus.ovf_out), 128'(0));
    check_output("rst_data", bus.data_out, 128'(0));

    // Table-driven frames
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Latency: valid three clocks after the terminating sck pin rise (LJ)
    do_reset();
    mode_in = 1'b1;
    bus.data_ready_in = 1'b1;
    start = beats;
    send_half(1'b1, 24'h0, 24'h0, 1'b0, 2);
    send_half(1'b0, 24'hA5A5A5, 24'h0, 1'b0, 32);
    send_half(1'b1, 24'h5A5A5A, 24'h0, 1'b0, 32);
    sck_in = 1'b0; ws_in = 1'b0; sd_in = 2'b00;
    repeat (4) @(negedge clk_in);
    sck_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_output("lat_valid_2clk", 128'(bus.data_valid_out), 128'(0));
    @(negedge clk_in);
    check_output("lat_valid_3clk", 128'(bus.data_valid_out), 128'(1));
    check_output("lat_ch0", 128'(bus.data_out[31:0]), 128'(pick(32'hA5A5A500, 32'hFFA5A5A5)));
    @(negedge clk_in);
    check_output("lat_valid_drain", 128'(bus.data_valid_out), 128'(0));
    check_output("lat_beats", 128'(beats - start), 128'(1));

    // Overflow: ready low across two frames, then clear
    do_reset();
    mode_in = 1'b0;
    bus.data_ready_in = 1'b0;
    start = beats;
    send_half(1'b1, 24'h0, 24'h0, 1'b0, 2);
    send_half(1'b0, 24'h111111, 24'h0, 1'b0, 32);
    send_half(1'b1, 24'h222222, 24'h0, 1'b0, 32);
    send_half(1'b0, 24'h333333, 24'h0, 1'b0, 32);
    send_half(1'b1, 24'h444444, 24'h0, 1'b0, 32);
    send_half(1'b0, 24'h0, 24'h0, 1'b0, 1);
    repeat (2) @(negedge clk_in);
    check_output("ovf_valid", 128'(bus.data_valid_out), 128'(1));
    check_output("ovf_flag", 128'(bus.ovf_out), 128'(1));
    check_output("ovf_ch0", 128'(bus.data_out[31:0]), 128'(pick(32'h11111100, 32'h00111111)));
    check_output("ovf_ch1", 128'(bus.data_out[63:32]), 128'(pick(32'h22222200, 32'h00222222)));
    check_output("ovf_beats", 128'(beats - start), 128'(0));
    bus.ovf_clr_in = 1'b1;
    @(negedge clk_in);
    bus.ovf_clr_in = 1'b0;
    check_output("ovf_cleared", 128'(bus.ovf_out), 128'(0));
    bus.data_ready_in = 1'b1;
    @(negedge clk_in);
    check_output("ovf_drain_valid", 128'(bus.data_valid_out), 128'(0));
    check_output("ovf_hold_ch0", 128'(bus.data_out[31:0]), 128'(pick(32'h11111100, 32'h00111111)));

    // Reset released mid right half: partial frame dropped, next frame delivered
    do_reset();
    mode_in = 1'b1;
    bus.data_ready_in = 1'b1;
    start = beats;
    send_half(1'b1, 24'h0, 24'h0, 1'b0, 2);
    send_half(1'b0, 24'h0F0F0F, 24'h0, 1'b0, 32);
    send_half(1'b1, 24'h135791, 24'h0, 1'b0, 10);
    @(negedge clk_in);
    sck_in = 1'b0;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    send_half(1'b1, 24'h135791, 24'h0, 1'b0, 22);
    send_half(1'b0, 24'hC0FFEE, 24'h0, 1'b0, 32);
    send_half(1'b1, 24'hBEEF01, 24'h0, 1'b0, 32);
    send_half(1'b0, 24'h0, 24'h0, 1'b0, 1);
    repeat (2) @(negedge clk_in);
    check_output("midrst_beats", 128'(beats - start), 128'(1));
    check_output("midrst_ch0", 128'(last_frame[31:0]), 128'(pick(32'hC0FFEE00, 32'hFFC0FFEE)));
    check_output("midrst_ch1", 128'(last_frame[63:32]), 128'(pick(32'hBEEF0100, 32'hFFBEEF01)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
